// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage handshake and HI/LO result bus between the pipeline and the mul/div unit.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, opa, opb, flush,
        input  stall, busy, done, hi, lo
    );

    modport slave (
        input  start, op, opa, opb, flush,
        output stall, busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_iter_step.sv
// One iteration of the mul/div datapath: shift-add multiply or restoring divide.
module muldiv_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc_i,     // partial product high word / partial remainder
    input  logic [WIDTH-1:0] opnd_i,    // multiplicand or divisor magnitude
    input  logic [WIDTH-1:0] mq_i,      // multiplier / dividend-quotient shift register
    input  logic             is_div_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] mq_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Multiply shifts {acc,mq} right after a conditional add; divide shifts left
    // and keeps the trial difference only when it did not borrow.
    always_comb begin
        sum     = {1'b0, acc_i} + (mq_i[0] ? {1'b0, opnd_i} : '0);
        shifted = {acc_i, mq_i[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_i};
        if (is_div_i) begin
            if (!diff[WIDTH]) begin
                acc_o = diff[WIDTH-1:0];
                mq_o  = {mq_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = shifted[WIDTH-1:0];
                mq_o  = {mq_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = sum[WIDTH:1];
            mq_o  = {sum[0], mq_i[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer writing architectural HI/LO.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    muldiv_sequencer_if.slave   bus
);
    state_e             state_q;
    op_e                op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   mq_q;
    logic [WIDTH-1:0]   dr_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   mq_d;
    logic               is_div_q;
    logic               is_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);

    muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .opnd_i   (dr_q),
        .mq_i     (mq_q),
        .is_div_i (is_div_q),
        .acc_o    (acc_d),
        .mq_o     (mq_d)
    );

    // Operand magnitudes at issue and sign-corrected results for the FIX edge.
    // The most negative value maps onto itself, which is correct read as unsigned.
    always_comb begin
        is_signed = ~bus.op[0];
        a_mag     = (is_signed && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
        b_mag     = (is_signed && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;
        prod      = {acc_q, mq_q};
        if (neg_res_q) prod = -prod;
        quo       = neg_res_q ? -mq_q : mq_q;
        rem       = neg_rem_q ? -acc_q : acc_q;
    end

    // Control FSM plus all datapath and HI/LO registers; flush outranks start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_MULT;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            mq_q      <= '0;
            dr_q      <= '0;
            a_raw_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        state_q   <= S_PREP;
                        op_q      <= op_e'(bus.op);
                        neg_res_q <= is_signed & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
                        neg_rem_q <= is_signed & bus.opa[WIDTH-1];
                        a_raw_q   <= bus.opa;
                        // mq shifts the multiplier or the dividend; dr is the fixed addend/divisor
                        if (bus.op[1]) begin
                            mq_q <= a_mag;
                            dr_q <= b_mag;
                        end else begin
                            mq_q <= b_mag;
                            dr_q <= a_mag;
                        end
                    end
                end
                S_PREP: begin
                    if (bus.flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= '0;
                        cnt_q <= '0;
                        if (is_div_q && dr_q == '0) begin
                            hi_q    <= a_raw_q;
                            lo_q    <= '1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        mq_q  <= mq_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH-1)) state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (bus.flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        if (is_div_q) begin
                            hi_q <= rem;
                            lo_q <= quo;
                        end else begin
                            hi_q <= prod[2*WIDTH-1:WIDTH];
                            lo_q <= prod[WIDTH-1:0];
                        end
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.stall = (bus.start && state_q == S_IDLE && !bus.flush) ||
                       (state_q inside {S_PREP, S_RUN, S_FIX});
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller that sequences an iterative multiply/divide unit beside the single-cycle ALU in the EX stage.
- Accepts MULT/MULTU/DIV/DIVU from EX.
- Holds the pipeline through `stall` while it iterates.
- Commits the 64-bit result into architectural HI/LO registers that later MFHI/MFLO read.
- Operands arrive already forwarded, i.e. the same values that feed the ALU inputs.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  EX holds a mul/div instruction; sampled only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- opa  input  WIDTH  forwarded Rs value (multiplicand or dividend).
- opb  input  WIDTH  forwarded Rt value (multiplier or divisor).
- flush  input  1  abort the current operation (branch or exception flush).
- stall  output  1  freeze PC, IF/ID and ID/EX.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse; HI/LO hold the new result.
- hi  output  WIDTH  HI register (product high word, or remainder).
- lo  output  WIDTH  LO register (product low word, or quotient).

Behaviour:
- Reset (synchronous):
  - state=IDLE, counter=0, hi=0, lo=0.
  - done=0, busy=0.
  - Internal accumulator and operand registers cleared.
- States:
  - IDLE -> PREP on start && !flush.
    - Latch op.
    - Latch signs for signed ops.
    - Convert signed operands to magnitudes; |0x80000000| = 0x80000000 treated as unsigned.
  - PREP -> RUN.
    - Clear the accumulator; counter=0.
    - Divide with opb==0: go to DONE directly. Write lo=all-ones, hi=opa (raw dividend), no sign fixing.
  - RUN: one iteration per cycle, WIDTH cycles, counter 0..WIDTH-1.
    - Multiply: shift-add on a {acc, multiplier} 2*WIDTH register.
    - Divide: restoring shift-subtract; quotient bit = no-borrow.
    - Exit to FIX when counter == WIDTH-1.
  - FIX: apply signs for signed ops.
    - Product negated if the operand signs differ.
    - Quotient negated if the signs differ.
    - Remainder takes the dividend's sign.
    - Write hi/lo on this edge. Go to DONE.
  - DONE: done=1 for exactly this cycle. Go to IDLE.
- Latency, start at cycle 0:
  - Normal op: PREP at cycle 1, RUN cycles 2..WIDTH+1, FIX at WIDTH+2, DONE at WIDTH+3 (cycle 35 for WIDTH=32).
  - Divide by zero: DONE at cycle 2.
- stall = (start && state==IDLE && !flush) || (state inside {PREP, RUN, FIX}).
  - stall is combinational.
  - stall is low in DONE, so the instruction leaves EX on the DONE edge.
- busy = (state != IDLE).
- hi/lo change only on the FIX edge, the divide-by-zero PREP edge, or reset. Otherwise they are held.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap.
- flush in any non-IDLE state: next state IDLE; hi/lo unchanged; no done pulse.
- flush in DONE: no effect, because hi/lo are already written.
- start while busy: ignored. The pipeline is stalled, so start stays asserted for the same instruction.
- start in the DONE cycle: ignored, because the state is not IDLE.
- rst has priority over flush, and flush has priority over start.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state encodings: S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE (3 bits).
- One sub-module, muldiv_iter_step: combinational single-iteration datapath.
  - Inputs: acc, operand register, op-is-div.
  - Outputs: next acc and next shift register.
  - The sequencer owns all registers and the FSM.

Test Plan:
- MULTU opa=0xFFFFFFFF opb=0xFFFFFFFF, start at cycle 0 -> stall high cycles 0..34; done at cycle 35; hi=0xFFFFFFFE, lo=0x00000001.
- MULT opa=0xFFFFFFFD (-3) opb=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV opa=0xFFFFFFF9 (-7) opb=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU opa=100 opb=0 -> done at cycle 2; lo=0xFFFFFFFF, hi=100.
- DIV opa=0x80000000 opb=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi=5, lo=6 via an earlier op. Start MULTU, assert flush at cycle 10 -> state IDLE at cycle 11; no done; hi=5, lo=6; stall low at cycle 11.
- Assert rst at cycle 20 of a DIVU -> next cycle hi=lo=0, busy=0, stall=0 (with start low).
